majority_voter_seq: RTL

- Parametrised, clocked successor to the team's 7-input combinational voter.
- Opens a voting window on request and latches each voter's first yes/no press, locking it against later changes.
- Closes the window on command or when every voter has voted, then tallies the yes votes serially and reports pass/fail plus the yes count.
- Sits behind the debounced push-button front end and drives the board LED/seven-segment display logic.

---
 rtl/majority_voter_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/majority_voter_seq.sv
// Sequential majority voter: opens a window, latches each voter's first press, tallies yes votes serially.
// Optional auto-close window timeout is enabled by defining VOTER_TIMEOUT_EN.
module majority_voter_seq #(
    parameter int N_VOTERS      = 7,
    parameter int THRESHOLD     = (N_VOTERS + 1) / 2,
    parameter int WINDOW_CYCLES = 1000,
    localparam int CW = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic [N_VOTERS-1:0] vote_no,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       yes_count,
    output logic                timed_out,
    output logic [1:0]          fsm_state
);
    localparam int IW = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, COUNT, RESULT} state_t;

    state_t                state;
    state_t                state_nx;
    logic [N_VOTERS-1:0]   yes_mask;
    logic [N_VOTERS-1:0]   new_voted;
    logic [N_VOTERS-1:0]   new_yes;
    logic [IW-1:0]         index;
    logic [CW-1:0]         tally;
    logic                  all_voted;
    logic                  timeout_hit;

    assign fsm_state = state;

    // A voter's first press wins; yes and no together records a no.
    assign new_voted = voted_mask | vote_yes | vote_no;
    assign new_yes   = yes_mask | (~voted_mask & vote_yes & ~vote_no);
    assign all_voted = &new_voted;

`ifdef VOTER_TIMEOUT_EN
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    logic [WW-1:0] win_cnt;

    assign timeout_hit = (win_cnt == WW'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            timed_out <= 1'b0;
        end else if (state == IDLE && start) begin
            win_cnt   <= '0;
            timed_out <= 1'b0;
        end else if (state == OPEN) begin
            win_cnt <= win_cnt + 1'b1;
            // close or all-voted on the expiry edge takes priority over the timeout
            if (timeout_hit && !close && !all_voted)
                timed_out <= 1'b1;
        end
    end
`else
    logic unused_window;
    assign unused_window = (WINDOW_CYCLES > 0);
    assign timeout_hit   = 1'b0;
    assign timed_out     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = OPEN;
            OPEN:    if (close || all_voted || timeout_hit) state_nx = COUNT;
            COUNT:   if (index == IW'(N_VOTERS - 1)) state_nx = RESULT;
            RESULT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            yes_count  <= '0;
            voted_mask <= '0;
            yes_mask   <= '0;
            index      <= '0;
            tally      <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        voted_mask <= '0;
                        yes_mask   <= '0;
                        tally      <= '0;
                    end
                end
                OPEN: begin
                    voted_mask <= new_voted;
                    yes_mask   <= new_yes;
                    index      <= '0;
                end
                COUNT: begin
                    tally <= tally + CW'(yes_mask[index]);
                    index <= index + 1'b1;
                end
                RESULT: begin
                    yes_count <= tally;
                    pass      <= (tally >= CW'(THRESHOLD));
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
